// File: rtl/pipe_skid_buf_pkg.sv
// Shared CPU pipeline package: skid-buffer state encodings and the default datapath width.
package pipe_skid_buf_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf_if.sv
// Valid/ready/data handshake bundle between pipeline stages.
interface pipe_skid_buf_if #(
  parameter int unsigned DW = 32
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_ctrl.sv
// Skid-buffer control FSM: occupancy state, ready/valid decode and data-register load strobes.
// Optional synchronous flush when PIPE_SKID_FLUSH_EN is defined.
module pipe_skid_ctrl
  import pipe_skid_buf_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic       flush_i,
`endif
  input  logic       in_valid_i,
  input  logic       out_ready_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [1:0] count_o,
  output logic       main_ld_o,
  output logic       main_sel_skid_o,
  output logic       skid_ld_o
);

  skid_state_e state_q, state_d;
  logic        in_fire, out_fire, flush;

`ifdef PIPE_SKID_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Fires decode from state only, so in_ready never depends on out_ready.
  assign in_fire  = in_valid_i  & (state_q != SKID_FULL);
  assign out_fire = out_ready_i & (state_q != SKID_EMPTY);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: if (in_fire) state_d = SKID_BUSY;
        SKID_BUSY: begin
          if (in_fire && !out_fire)      state_d = SKID_FULL;
          else if (!in_fire && out_fire) state_d = SKID_EMPTY;
        end
        SKID_FULL:  if (out_fire) state_d = SKID_BUSY;
        default:    state_d = SKID_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready_o      = (state_q != SKID_FULL);
    out_valid_o     = (state_q != SKID_EMPTY);
    count_o         = state_q;
    main_ld_o       = 1'b0;
    main_sel_skid_o = 1'b0;
    skid_ld_o       = 1'b0;
    // Flush leaves the data registers untouched.
    if (!flush) begin
      case (state_q)
        SKID_EMPTY: main_ld_o = in_fire;
        SKID_BUSY: begin
          main_ld_o = in_fire & out_fire;
          skid_ld_o = in_fire & ~out_fire;
        end
        SKID_FULL: begin
          main_ld_o       = out_fire;
          main_sel_skid_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready pipeline stage with skid register; in_ready is a pure register decode.
// Optional flush port enabled by PIPE_SKID_FLUSH_EN.
module pipe_skid_buf
  import pipe_skid_buf_pkg::*;
#(
  parameter int unsigned    DW        = XLEN,
  parameter logic [DW-1:0]  RST_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic                 flush_i,
`endif
  pipe_skid_buf_if.slave       in_if,
  pipe_skid_buf_if.master      out_if,
  output logic [1:0]           count_o
);

  logic          in_ready, out_valid;
  logic          main_ld, main_sel_skid, skid_ld;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;

  pipe_skid_ctrl u_ctrl (
    .clk             (clk),
    .rstn            (rstn),
`ifdef PIPE_SKID_FLUSH_EN
    .flush_i         (flush_i),
`endif
    .in_valid_i      (in_if.valid),
    .out_ready_i     (out_if.ready),
    .in_ready_o      (in_ready),
    .out_valid_o     (out_valid),
    .count_o         (count_o),
    .main_ld_o       (main_ld),
    .main_sel_skid_o (main_sel_skid),
    .skid_ld_o       (skid_ld)
  );

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (main_ld) main_d = main_sel_skid ? skid_q : in_if.data;
    if (skid_ld) skid_d = in_if.data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      main_q <= RST_VALUE;
      skid_q <= RST_VALUE;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_q;

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Table-driven bench for pipe_skid_buf with a FIFO scoreboard of accepted payloads.
// Flush rows are added when PIPE_SKID_FLUSH_EN is defined.
module tb_pipe_skid_buf;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush;
  logic [1:0] count;

  pipe_skid_buf_if #(.DW(32)) in_if ();
  pipe_skid_buf_if #(.DW(32)) out_if ();

  pipe_skid_buf #(.DW(32), .RST_VALUE(32'h0)) dut (
    .clk     (clk),
    .rstn    (rstn),
`ifdef PIPE_SKID_FLUSH_EN
    .flush_i (flush),
`endif
    .in_if   (in_if),
    .out_if  (out_if),
    .count_o (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        chk;
    logic        ov;
    logic        ir;
    logic [1:0]  cnt;
    logic [31:0] od;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                              input logic [31:0] d, input logic ordy, input logic chk,
                              input logic ov, input logic ir, input logic [1:0] cnt,
                              input logic [31:0] od);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.chk = chk; v.ov = ov; v.ir = ir; v.cnt = cnt; v.od = od;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] e;

    rstn        = 1'b0;
    flush       = 1'b0;
    in_if.valid = 1'b0;
    in_if.data  = '0;
    out_if.ready = 1'b0;

    // Expected columns describe the outputs seen before the row's inputs take effect.
    //             rst fl iv  d      ordy chk ov ir cnt od
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 1, 0, 1, 0, 32'h0));
    // Streaming at full throughput.
    vecs.push_back(mk(0, 0, 1, 32'h11, 1, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h22, 1, 1, 1, 1, 1, 32'h11));
    vecs.push_back(mk(0, 0, 1, 32'h33, 1, 1, 1, 1, 1, 32'h22));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 1, 1, 1, 1, 32'h33));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 1, 0, 1, 0, 32'h33));
    // Stall to FULL, offer an ignored 0xC, then drain.
    vecs.push_back(mk(0, 0, 1, 32'hA,  0, 1, 0, 1, 0, 32'h33));
    vecs.push_back(mk(0, 0, 1, 32'hB,  0, 1, 1, 1, 1, 32'hA));
    vecs.push_back(mk(0, 0, 1, 32'hC,  0, 1, 1, 0, 2, 32'hA));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 1, 1, 0, 2, 32'hA));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 1, 1, 1, 1, 32'hB));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 1, 0, 1, 0, 32'hB));
    // Simultaneous accept and deliver in BUSY.
    vecs.push_back(mk(0, 0, 1, 32'h5,  0, 1, 0, 1, 0, 32'hB));
    vecs.push_back(mk(0, 0, 1, 32'h6,  1, 1, 1, 1, 1, 32'h5));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 1, 1, 1, 1, 32'h6));
    // Fill to FULL, then reset with traffic offered on both sides.
    vecs.push_back(mk(0, 0, 1, 32'h7,  0, 1, 1, 1, 1, 32'h6));
    vecs.push_back(mk(1, 0, 1, 32'h8,  1, 1, 1, 0, 2, 32'h6));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h9,  1, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 1, 1, 1, 1, 32'h9));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 1, 0, 1, 0, 32'h9));
`ifdef PIPE_SKID_FLUSH_EN
    // Flush in FULL with in_valid high; data registers keep 0x41.
    vecs.push_back(mk(0, 0, 1, 32'h41, 0, 1, 0, 1, 0, 32'h9));
    vecs.push_back(mk(0, 0, 1, 32'h42, 0, 1, 1, 1, 1, 32'h41));
    vecs.push_back(mk(0, 1, 1, 32'h43, 0, 1, 1, 0, 2, 32'h41));
    vecs.push_back(mk(0, 0, 1, 32'h77, 0, 1, 0, 1, 0, 32'h41));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 1, 1, 1, 1, 32'h77));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 1, 0, 1, 0, 32'h77));
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      v = vecs[i];
      if (v.chk) begin
        cmp("out_valid", i, {31'b0, out_if.valid}, {31'b0, v.ov});
        cmp("in_ready",  i, {31'b0, in_if.ready},  {31'b0, v.ir});
        cmp("count",     i, {30'b0, count},        {30'b0, v.cnt});
        cmp("out_data",  i, out_if.data,           v.od);
      end
      if (v.rst) begin
        sb.delete();
      end else begin
        if (v.ordy && v.ov) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_order row %0d: got delivery 0x%0h, expected none", i,
                     out_if.data);
          end else begin
            e = sb.pop_front();
            cmp("sb_data", i, out_if.data, e);
          end
        end
        if (v.fl) sb.delete();
        else if (v.iv && v.ir) sb.push_back(v.d);
      end
      rstn         = ~v.rst;
      flush        = v.fl;
      in_if.valid  = v.iv;
      in_if.data   = v.d;
      out_if.ready = v.ordy;
    end

    @(negedge clk);
    cmp("sb_drained", vecs.size(), sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
